// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: op codes, FSM states, bit reverse.
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P1   = 2'd1,
        ST_P2   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Mirror a 32-bit word so right shifts can reuse the left shifter.
    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

endpackage

// File: rtl/lsl32.sv
// Combinational 32-bit logical left shifter; amounts of 32 or more give zero.
module lsl32 (
    input  logic [31:0] data,
    input  logic [5:0]  amt,
    output logic [31:0] y
);

    // amt[5] covers every amount >= 32; below that a plain shift applies.
    always_comb begin
        y = amt[5] ? 32'h0 : (data << amt[4:0]);
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end sharing one left shifter for
// SLL/SRL/SRA/ROL; right shifts wrap the shifter in bit reversals.
module shift_arbiter
    import shift_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_data
);

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        id_q, id_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic [1:0]  ready_int;
    logic        gnt;
    logic [31:0] sh_x, sh_y, res;
    logic [5:0]  sh_amt;
    logic        ovf;
    logic [4:0]  n;

    assign ovf = |b_q[31:5];
    assign n   = b_q[4:0];

    lsl32 u_lsl32 (
        .data (sh_x),
        .amt  (sh_amt),
        .y    (sh_y)
    );

    // Arbitration, shifter operand steering and next-state logic.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        acc_d        = acc_q;
        rsp_data_d   = rsp_data_q;
        ready_int    = 2'b00;
        gnt          = 1'b0;
        sh_x         = 32'h0;
        sh_amt       = 6'd0;
        res          = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    // On a tie the requester not served last wins.
                    gnt          = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
                    ready_int    = gnt ? 2'b10 : 2'b01;
                    op_d         = gnt ? req_op[3:2]  : req_op[1:0];
                    a_d          = gnt ? req_a[63:32] : req_a[31:0];
                    b_d          = gnt ? req_b[63:32] : req_b[31:0];
                    id_d         = gnt;
                    last_grant_d = gnt;
                    state_d      = ST_P1;
                end
            end
            ST_P1: begin
                sh_x   = (op_q == OP_SLL || op_q == OP_ROL) ? a_q : rev32(a_q);
                sh_amt = {1'b0, n};
                case (op_q)
                    OP_SLL:  res = ovf ? 32'h0 : sh_y;
                    OP_ROL:  res = sh_y;
                    default: res = ovf ? 32'h0 : rev32(sh_y);
                endcase
                acc_d = res;
                if (op_q == OP_SLL || op_q == OP_SRL) begin
                    rsp_data_d = res;
                    state_d    = ST_RESP;
                end else begin
                    state_d = ST_P2;
                end
            end
            ST_P2: begin
                if (op_q == OP_SRA) begin
                    // Sign fill: reversed left-shifted ones mask the vacated top bits.
                    sh_x   = 32'hFFFF_FFFF;
                    sh_amt = {1'b0, n};
                    res    = ovf ? {32{a_q[31]}}
                                 : (acc_q | (a_q[31] ? ~rev32(sh_y) : 32'h0));
                end else begin
                    // Wrapped bits: a right shift by 32-n; n=0 gives amount 32, i.e. zero.
                    sh_x   = rev32(a_q);
                    sh_amt = 6'd32 - {1'b0, n};
                    res    = acc_q | rev32(sh_y);
                end
                acc_d      = res;
                rsp_data_d = res;
                state_d    = ST_RESP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_SLL;
            a_q          <= 32'h0;
            b_q          <= 32'h0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            acc_q        <= 32'h0;
            rsp_data_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            acc_q        <= acc_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    // Response pulse is decoded from the registered state; ready is masked in reset.
    always_comb begin
        req_ready = rst ? 2'b00 : ready_int;
        rsp_valid = (state_q == ST_RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
        rsp_data  = rsp_data_q;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Sequencer and round-robin arbiter that shares one 32-bit logical-left barrel shifter (`lsl32`) between two requesters in the ALU32 datapath. It issues SLL, SRL, SRA and ROL. Right shifts are built by bit-reversing the operand and the result around the left shifter. SRA and ROL take two shifter passes. Results return on a registered response port tagged per requester.

## Interface
Parameters:
- none; widths are fixed at 32 data bits and 2 requesters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  per-requester request valid.
- `req_ready`  out  2  per-requester accept; one-hot or zero.
- `req_op`  in  4  op for requester i at bits [2i+1:2i]: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- `req_a`  in  64  operand A for requester i at bits [32i+31:32i].
- `req_b`  in  64  shift amount B for requester i at bits [32i+31:32i].
- `rsp_valid`  out  2  one-cycle pulse to the requester that owns the result.
- `rsp_data`  out  32  result, valid when any `rsp_valid` bit is set.

## Operation
- FSM states: IDLE, P1, P2, RESP.
- **IDLE**
  - If any `req_valid` is set, grant one requester and assert its `req_ready` in that cycle (handshake).
  - Latch op, A, B and the grant id, then go to P1.
- **Arbitration**
  - A single valid requester wins.
  - If both are valid, grant the requester that was not granted last.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
- **Overflow flag** `ovf` = OR of B[31:5]. Shift amount n = B[4:0].
- **P1** (shifter input X, amount n; result stored in `acc`):
  - SLL: X=A; `acc` = ovf ? 0 : lsl(A,n).
  - SRL: X=rev(A); `acc` = ovf ? 0 : rev(lsl(rev(A),n)).
  - SRA: same as SRL.
  - ROL: `acc` = lsl(A,n); ovf is ignored.
  - SLL and SRL then go to RESP; SRA and ROL go to P2.
- **P2**
  - SRA: `acc` = ovf ? {32{A[31]}} : `acc` | (A[31] ? ~rev(lsl(32'hFFFF_FFFF,n)) : 0).
  - ROL: `acc` = `acc` | rev(lsl(rev(A),32-n)). The amount is 6 bits; 32-n=32 yields 0, so n=0 returns A.
  - Then go to RESP.
- **RESP**
  - `rsp_valid[id]`=1 and `rsp_data`=`acc` for exactly one cycle.
  - There is no response backpressure; the requester must accept.
  - Go to IDLE.
- **Ready rules**
  - `req_ready` is 0 outside IDLE and 0 while `rst` is high.
  - A valid request held while the block is busy is neither lost nor duplicated; it waits for IDLE.
- **Reset**
  - Reset during any state aborts the in-flight operation; no response is ever issued for it.
  - Reset values: state=IDLE, `acc`=0, `rsp_valid`=0, `rsp_data`=0, `last_grant`=1.

## Timing
- Handshake in cycle t (IDLE).
- SLL/SRL: P1 at t+1, `rsp_valid` at t+2.
- SRA/ROL: P1 at t+1, P2 at t+2, `rsp_valid` at t+3.
- Next handshake is possible at t+3 for single-pass ops and t+4 for two-pass ops.
  - Peak throughput: one op per 3 cycles.
- `rsp_data` is registered and holds its last value outside RESP.
- `req_ready` is combinational from `req_valid`, state and `last_grant`.

## Structure
- Package `shift_pkg`:
  - op encoding constants `OP_SLL`, `OP_SRL`, `OP_SRA`, `OP_ROL`;
  - FSM state typedef;
  - `rev32` bit-reverse function.
- Sub-module `lsl32`: combinational 32-bit logical left shift, inputs (data[31:0], amt[5:0]), output 0 when amt≥32. It is instantiated exactly once and is the only shifter in the block.

## Test plan
- SLL via requester 0:
  - A=0x0000_0001, B=31 → 0x8000_0000 with `rsp_valid[0]` 2 cycles after handshake.
  - B=32 → 0x0000_0000.
  - B=0x8000_0000 → 0x0000_0000.
- SRL A=0xF000_0000, B=4 → 0x0F00_0000.
- SRA (latency 3):
  - A=0x8000_0000, B=4 → 0xF800_0000.
  - A=0x8000_0000, B=0x100 → 0xFFFF_FFFF.
  - A=0x7000_0000, B=4 → 0x0700_0000.
- ROL:
  - A=0x8000_0001, B=1 → 0x0000_0003.
  - B=0 → 0x8000_0001.
  - B=33 → 0x0000_0003.
- Both `req_valid` held high for 6 requests:
  - grants alternate 0,1,0,1,0,1;
  - each `rsp_valid` goes to the matching bit;
  - `req_ready` is never set for both requesters at once.
- Reset mid-operation:
  - assert `rst` in P2 of an SRA → no `rsp_valid` pulse, all outputs 0.
  - After deassert, requester 1 alone SLL A=0x3, B=2 → 0x0000_000C.
